// File: rtl/gcd_controller_if.sv
// Handshake and control bundle between the GCD controller and its datapath.
// Latency: none, wires only.
// Backpressure: none here; operand flow is paced by data_valid.
interface gcd_controller_if;
  logic        start;
  logic        abort;
  logic        data_valid;
  logic [15:0] data_in;
  logic        gt;
  logic        lt;
  logic        eq;
  logic        lda;
  logic        ldb;
  logic        sel1;
  logic        sel2;
  logic        sel_in;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [15:0] iter_count;

  // Datapath / requester side
  modport master (
    output start, abort, data_valid, data_in, gt, lt, eq,
    input  lda, ldb, sel1, sel2, sel_in, busy, done, err, err_code, iter_count
  );

  // Controller side
  modport slave (
    input  start, abort, data_valid, data_in, gt, lt, eq,
    output lda, ldb, sel1, sel2, sel_in, busy, done, err, err_code, iter_count
  );
endinterface

// File: rtl/gcd_controller.sv
// Subtractive GCD controller steering an external A/B register datapath.
// Latency: accepted start to done is 4 + N cycles (N subtract steps).
// Backpressure: operand loads stall while data_valid is low; abort cancels a run.
module gcd_controller #(
  parameter int unsigned MAX_ITER = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  gcd_controller_if.slave  bus
);

  localparam logic [15:0] MAX_CNT = 16'(MAX_ITER);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_CALC,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic        zero_q, zero_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [15:0] iter_q, iter_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  logic lda_c, ldb_c, sel1_c, sel2_c, sel_in_c;
  logic gt_only, lt_only, eq_only;

  // Only a single asserted comparator output is trusted; anything else idles.
  assign gt_only = bus.gt & ~bus.lt & ~bus.eq;
  assign lt_only = bus.lt & ~bus.gt & ~bus.eq;
  assign eq_only = bus.eq & ~bus.gt & ~bus.lt;

  // Next-state, status update and datapath control decode.
  always_comb begin
    state_d    = state_q;
    zero_d     = zero_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    iter_d     = iter_q;
    lda_c      = 1'b0;
    ldb_c      = 1'b0;
    sel1_c     = 1'b0;
    sel2_c     = 1'b0;
    sel_in_c   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d    = S_LOAD_A;
          zero_d     = 1'b0;
          err_d      = 1'b0;
          err_code_d = 2'b00;
          iter_d     = '0;
        end
      end
      S_LOAD_A: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (bus.data_valid) begin
          sel_in_c = 1'b1;
          lda_c    = 1'b1;
          zero_d   = (bus.data_in == 16'd0);
          state_d  = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (bus.data_valid) begin
          sel_in_c = 1'b1;
          ldb_c    = 1'b1;
          zero_d   = zero_q | (bus.data_in == 16'd0);
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (zero_q) begin
          state_d    = S_ERROR;
          err_d      = 1'b1;
          err_code_d = 2'b01;
        end else if ((iter_q == MAX_CNT) && !eq_only) begin
          // Step budget exhausted: stop before issuing another subtract.
          state_d    = S_ERROR;
          err_d      = 1'b1;
          err_code_d = 2'b10;
        end else if (eq_only) begin
          state_d = S_DONE;
        end else if (gt_only) begin
          sel2_c = 1'b1;
          lda_c  = 1'b1;
          iter_d = iter_q + 16'd1;
        end else if (lt_only) begin
          sel1_c = 1'b1;
          ldb_c  = 1'b1;
          iter_d = iter_q + 16'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  // State and status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      zero_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      iter_q     <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      zero_q     <= zero_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      iter_q     <= iter_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  // Controls are forced low while reset is held so the datapath never loads.
  assign bus.lda        = lda_c    & rst_n;
  assign bus.ldb        = ldb_c    & rst_n;
  assign bus.sel1       = sel1_c   & rst_n;
  assign bus.sel2       = sel2_c   & rst_n;
  assign bus.sel_in     = sel_in_c & rst_n;
  assign bus.busy       = busy_q   & rst_n;
  assign bus.done       = done_q   & rst_n;
  assign bus.err        = err_q;
  assign bus.err_code   = err_code_q;
  assign bus.iter_count = iter_q;

endmodule

// File: tb/tb_gcd_controller.sv
// Directed bench: controller plus a behavioural A/B subtractor datapath.
// Latency: checks done/err timing cycle-exactly against start.
// Backpressure: exercises data_valid stalls, abort and reset mid-run.
module tb_gcd_controller;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   cyc;

  gcd_controller_if dif ();

  gcd_controller #(.MAX_ITER(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural datapath: two registers, a subtractor and the bus mux.
  logic [15:0] a_q, b_q, minuend, subtrahend, bus_val;
  logic [16:0] trace[$];

  assign minuend    = dif.sel1 ? b_q : a_q;
  assign subtrahend = dif.sel2 ? b_q : a_q;
  assign bus_val    = dif.sel_in ? dif.data_in : (minuend - subtrahend);
  assign dif.gt     = (a_q > b_q);
  assign dif.lt     = (a_q < b_q);
  assign dif.eq     = (a_q == b_q);

  // Register loads, plus a log of every subtract write as {is_b, value}.
  always @(posedge clk) begin
    if (dif.lda) a_q <= bus_val;
    if (dif.ldb) b_q <= bus_val;
    if ((dif.lda || dif.ldb) && !dif.sel_in) trace.push_back({dif.ldb, bus_val});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Accepts a start and feeds both operands; returns at the first CALC cycle.
  task automatic do_start(input logic [15:0] a, input logic [15:0] b, input int stall,
                          output int c0);
    @(negedge clk);
    trace.delete();
    c0 = cyc;
    dif.start      = 1'b1;
    dif.data_valid = 1'b0;
    @(negedge clk);
    dif.start      = 1'b0;
    dif.data_in    = a;
    dif.data_valid = 1'b1;
    @(negedge clk);
    dif.data_in = b;
    for (int i = 0; i < stall; i++) begin
      dif.data_valid = 1'b0;
      #1;
      check("stall_no_ldb", {31'd0, dif.ldb}, 32'd0);
      @(negedge clk);
    end
    dif.data_valid = 1'b1;
    @(negedge clk);
    dif.data_valid = 1'b0;
  endtask

  // Waits (bounded) for done or the ERROR state; lat = cycles since start.
  task automatic wait_end(input int c0, output int lat);
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      if (dif.done || (dif.err && dif.busy)) begin
        lat = cyc - c0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_expect_done(input string tag, input logic [15:0] a, input logic [15:0] b,
                                 input int stall, input int exp_lat, input int exp_iter,
                                 input logic [15:0] exp_gcd);
    int c0, lat;
    do_start(a, b, stall, c0);
    wait_end(c0, lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_done"}, {31'd0, dif.done}, 32'd1);
    check({tag, "_iter"}, {16'd0, dif.iter_count}, exp_iter);
    check({tag, "_err"}, {31'd0, dif.err}, 32'd0);
    check({tag, "_a"}, {16'd0, a_q}, {16'd0, exp_gcd});
    check({tag, "_b"}, {16'd0, b_q}, {16'd0, exp_gcd});
    @(negedge clk);
    check({tag, "_pulse"}, {30'd0, dif.done, dif.busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, lat;
    n_checks       = 0;
    n_errors       = 0;
    cyc            = 0;
    rst_n          = 1'b0;
    dif.start      = 1'b0;
    dif.abort      = 1'b0;
    dif.data_valid = 1'b0;
    dif.data_in    = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_ctrl", {27'd0, dif.lda, dif.ldb, dif.sel1, dif.sel2, dif.sel_in}, 32'd0);
    check("rst_status", {28'd0, dif.busy, dif.done, dif.err_code}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_err_iter", {15'd0, dif.err, dif.iter_count}, 32'd0);

    // 12, 8: A 12->4, then B 8->4
    run_expect_done("g12_8", 16'd12, 16'd8, 0, 6, 2, 16'd4);
    check("g12_8_trace_n", trace.size(), 32'd2);
    check("g12_8_trace0", {15'd0, trace[0]}, {15'd0, 1'b0, 16'd4});
    check("g12_8_trace1", {15'd0, trace[1]}, {15'd0, 1'b1, 16'd4});

    // 48, 18: A 30, A 12, B 6, A 6; equality reached exactly at the step limit
    run_expect_done("g48_18", 16'd48, 16'd18, 0, 8, 4, 16'd6);
    check("g48_18_trace0", {15'd0, trace[0]}, {15'd0, 1'b0, 16'd30});
    check("g48_18_trace1", {15'd0, trace[1]}, {15'd0, 1'b0, 16'd12});
    check("g48_18_trace2", {15'd0, trace[2]}, {15'd0, 1'b1, 16'd6});
    check("g48_18_trace3", {15'd0, trace[3]}, {15'd0, 1'b0, 16'd6});

    // Zero operand: error without any subtract
    do_start(16'd0, 16'd5, 0, c0);
    wait_end(c0, lat);
    check("zero_lat", lat, 32'd4);
    check("zero_err", {29'd0, dif.err, dif.err_code}, {29'd0, 1'b1, 2'b01});
    check("zero_done", {31'd0, dif.done}, 32'd0);
    check("zero_iter", {16'd0, dif.iter_count}, 32'd0);
    check("zero_subs", trace.size(), 32'd0);
    @(negedge clk);
    check("zero_after", {30'd0, dif.busy, dif.err}, 32'd1);
    @(negedge clk);
    check("zero_err_held", {29'd0, dif.err, dif.err_code}, {29'd0, 1'b1, 2'b01});

    // Timeout with MAX_ITER=4: 65535,1 takes four A subtracts then errors
    do_start(16'hFFFF, 16'd1, 0, c0);
    check("err_cleared_on_start", {29'd0, dif.err, dif.err_code}, 32'd0);
    wait_end(c0, lat);
    check("tmo_lat", lat, 32'd8);
    check("tmo_err", {29'd0, dif.err, dif.err_code}, {29'd0, 1'b1, 2'b10});
    check("tmo_subs", trace.size(), 32'd4);
    check("tmo_a", {16'd0, a_q}, 32'd65531);
    check("tmo_iter", {16'd0, dif.iter_count}, 32'd4);
    @(negedge clk);
    check("tmo_after", {30'd0, dif.busy, dif.err}, 32'd1);

    // Stall three cycles in LOAD_B, then abort at the second CALC cycle
    do_start(16'd12, 16'd8, 3, c0);
    check("stall_b_loaded", {16'd0, b_q}, 32'd8);
    @(negedge clk);
    dif.abort = 1'b1;
    #1;
    check("abort_no_load", {30'd0, dif.lda, dif.ldb}, 32'd0);
    @(negedge clk);
    dif.abort = 1'b0;
    check("abort_idle", {29'd0, dif.busy, dif.done, dif.err}, 32'd0);
    check("abort_iter", {16'd0, dif.iter_count}, 32'd1);
    check("abort_b_kept", {16'd0, b_q}, 32'd8);
    run_expect_done("post_abort", 16'd48, 16'd18, 0, 8, 4, 16'd6);

    // Reset in the middle of CALC, then a fresh 7,7 run
    do_start(16'hFFFF, 16'd1, 0, c0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ctrl", {27'd0, dif.lda, dif.ldb, dif.sel1, dif.sel2, dif.sel_in}, 32'd0);
    check("rst_mid_busy", {30'd0, dif.busy, dif.done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_state", {13'd0, dif.busy, dif.err, dif.err_code, dif.iter_count}, 32'd0);
    run_expect_done("g7_7", 16'd7, 16'd7, 0, 4, 0, 16'd7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
